data_mem_arbiter: RTL and testbench

//  Two-port round-robin arbiter/sequencer in front of the single-port 256x8 Data_memory.

---
 rtl/data_mem_arbiter_if.sv | 43 ++++
 rtl/data_mem_arbiter.sv | 89 ++++++++
 tb/tb_data_mem_arbiter.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_arbiter_if.sv
// Request/response and memory-pin bundle between the two requesters, the arbiter and Data_memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface data_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              rsp0_valid;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              rsp1_valid;

  logic [DATA_W-1:0] rsp_rdata;

  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_datain;
  logic [DATA_W-1:0] mem_dataout;

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    input  mem_dataout,
    output req0_ready, rsp0_valid, req1_ready, rsp1_valid, rsp_rdata,
    output mem_write, mem_address, mem_datain
  );

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    output mem_dataout,
    input  req0_ready, rsp0_valid, req1_ready, rsp1_valid, rsp_rdata,
    input  mem_write, mem_address, mem_datain
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port Data_memory:
// grants one request in IDLE, runs a single ACCESS cycle, then pulses the owner's response.
module data_mem_arbiter #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIXED_PRIO = 0
) (
  input logic               clk,
  input logic               reset,
  data_mem_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state;
  logic   wr_q;
  logic   owner_q;
  logic   last_grant_q;
  logic   gnt0;
  logic   gnt1;

  // Grant decision: a lone requester wins; ties go to the port that did not win last,
  // or always to port 0 in fixed-priority builds.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if (FIXED_PRIO != 0 || last_grant_q) begin
          gnt0 = 1'b1;
        end else begin
          gnt1 = 1'b1;
        end
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  // Reset in the ACCESS cycle must stop an in-flight write before the memory's negedge.
  assign bus.mem_write = (state == ACCESS) & wr_q & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      wr_q            <= 1'b0;
      owner_q         <= 1'b0;
      last_grant_q    <= 1'b1;
      bus.rsp0_valid  <= 1'b0;
      bus.rsp1_valid  <= 1'b0;
      bus.rsp_rdata   <= DATA_W'(0);
      bus.mem_address <= ADDR_W'(0);
      bus.mem_datain  <= DATA_W'(0);
    end else begin
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt0 || gnt1) begin
            state           <= ACCESS;
            owner_q         <= gnt1;
            last_grant_q    <= gnt1;
            wr_q            <= gnt1 ? bus.req1_write : bus.req0_write;
            bus.mem_address <= gnt1 ? bus.req1_addr  : bus.req0_addr;
            bus.mem_datain  <= gnt1 ? bus.req1_wdata : bus.req0_wdata;
          end
        end
        ACCESS: begin
          // Memory has presented the read data by this closing edge.
          if (!wr_q) begin
            bus.rsp_rdata <= bus.mem_dataout;
          end
          bus.rsp0_valid <= ~owner_q;
          bus.rsp1_valid <= owner_q;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: round-robin and fixed-priority instances share stimulus,
// each with its own Data_memory model and transaction-level reference model.
module tb_data_mem_arbiter;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       r0v, r0w, r1v, r1w;
  logic [7:0] r0a, r0d, r1a, r1d;

  logic [1:0]      rdy0, rdy1, rsp0, rsp1, mwr;
  logic [1:0][7:0] rdata, maddr, mdin;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    data_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    logic [7:0] dmem [256] = '{default: 8'h00};
    logic [7:0] raddr = 8'h00;

    // Data_memory: writes or registers the read address on the negedge.
    always @(negedge clk) begin
      if (bus.mem_write) dmem[bus.mem_address] <= bus.mem_datain;
      else               raddr <= bus.mem_address;
    end
    assign bus.mem_dataout = dmem[raddr];

    assign bus.req0_valid = r0v;
    assign bus.req0_write = r0w;
    assign bus.req0_addr  = r0a;
    assign bus.req0_wdata = r0d;
    assign bus.req1_valid = r1v;
    assign bus.req1_write = r1w;
    assign bus.req1_addr  = r1a;
    assign bus.req1_wdata = r1d;

    assign rdy0[k]  = bus.req0_ready;
    assign rdy1[k]  = bus.req1_ready;
    assign rsp0[k]  = bus.rsp0_valid;
    assign rsp1[k]  = bus.rsp1_valid;
    assign mwr[k]   = bus.mem_write;
    assign rdata[k] = bus.rsp_rdata;
    assign maddr[k] = bus.mem_address;
    assign mdin[k]  = bus.mem_datain;

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(k)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  // Reference model state, one copy per instance (index 1 = fixed priority).
  logic       m_busy [2];
  logic       m_wr   [2];
  logic       m_own  [2];
  logic       m_last [2];
  logic [7:0] m_addr [2];
  logic [7:0] m_data [2];
  logic [7:0] e_rdata[2];
  logic       e_rsp0 [2];
  logic       e_rsp1 [2];
  logic [7:0] ref_mem [2][256];
  int         g_last [2];
  int         dut_g  [2];

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string tag, input int k, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s[%0d]: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_busy[k]  = 1'b0;
    m_wr[k]    = 1'b0;
    m_own[k]   = 1'b0;
    m_last[k]  = 1'b1;
    m_addr[k]  = 8'h00;
    m_data[k]  = 8'h00;
    e_rdata[k] = 8'h00;
    e_rsp0[k]  = 1'b0;
    e_rsp1[k]  = 1'b0;
  endtask

  task automatic drive(input logic v0, input logic w0, input logic [7:0] a0, input logic [7:0] d0,
                       input logic v1, input logic w1, input logic [7:0] a1, input logic [7:0] d1);
    r0v = v0; r0w = w0; r0a = a0; r0d = d0;
    r1v = v1; r1w = w1; r1a = a1; r1d = d1;
  endtask

  // One clock: inputs already driven just after the previous posedge.
  task automatic step();
    int g;
    #1;
    for (int k = 0; k < 2; k++) begin
      g = -1;
      if (!m_busy[k]) begin
        if (r0v && r1v) g = (k == 1 || m_last[k]) ? 0 : 1;
        else if (r0v)   g = 0;
        else if (r1v)   g = 1;
      end
      check("req0_ready", k, 32'(rdy0[k]), 32'(g == 0));
      check("req1_ready", k, 32'(rdy1[k]), 32'(g == 1));
      check("mem_write", k, 32'(mwr[k]), 32'(m_busy[k] && m_wr[k] && !reset));
      check("mem_address", k, 32'(maddr[k]), 32'(m_addr[k]));
      check("mem_datain", k, 32'(mdin[k]), 32'(m_data[k]));
      g_last[k] = g;
      dut_g[k]  = rdy1[k] ? 1 : (rdy0[k] ? 0 : -1);

      e_rsp0[k] = 1'b0;
      e_rsp1[k] = 1'b0;
      if (reset) begin
        model_reset(k);
      end else if (m_busy[k]) begin
        if (m_wr[k]) ref_mem[k][m_addr[k]] = m_data[k];
        else         e_rdata[k] = ref_mem[k][m_addr[k]];
        if (m_own[k]) e_rsp1[k] = 1'b1;
        else          e_rsp0[k] = 1'b1;
        m_busy[k] = 1'b0;
      end else if (g >= 0) begin
        m_busy[k] = 1'b1;
        m_own[k]  = (g == 1);
        m_last[k] = (g == 1);
        m_wr[k]   = (g == 1) ? r1w : r0w;
        m_addr[k] = (g == 1) ? r1a : r0a;
        m_data[k] = (g == 1) ? r1d : r0d;
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rsp0_valid", k, 32'(rsp0[k]), 32'(e_rsp0[k]));
      check("rsp1_valid", k, 32'(rsp1[k]), 32'(e_rsp1[k]));
      check("rsp_rdata", k, 32'(rdata[k]), 32'(e_rdata[k]));
    end
  endtask

  task automatic reset_step();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  function automatic logic [7:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 8'hFF;
      1:       return 8'h00;
      2:       return 8'($urandom_range(0, 255));
      default: return 8'($urandom_range(0, 15));
    endcase
  endfunction

  logic       p0v, p0w, p1v, p1w;
  logic [7:0] p0a, p0d, p1a, p1d;
  int         seq [2][4];

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 256; i++) ref_mem[k][i] = 8'h00;
      model_reset(k);
      g_last[k] = -1;
      dut_g[k]  = -1;
    end
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check("rst_rsp0", k, 32'(rsp0[k]), 32'(0));
      check("rst_rsp1", k, 32'(rsp1[k]), 32'(0));
      check("rst_rdata", k, 32'(rdata[k]), 32'(0));
      check("rst_mem_write", k, 32'(mwr[k]), 32'(0));
      check("rst_mem_address", k, 32'(maddr[k]), 32'(0));
      check("rst_mem_datain", k, 32'(mdin[k]), 32'(0));
    end
    reset = 1'b0;

    // Port 0 write 0x5A @0x10, then read it back.
    drive(1'b1, 1'b1, 8'h10, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00); step();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00); step();
    check("t1_wr_rsp0", 0, 32'(rsp0[0]), 32'(1));
    drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00); step();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00); step();
    check("t1_rd_rsp0", 0, 32'(rsp0[0]), 32'(1));
    check("t1_rd_rdata", 0, 32'(rdata[0]), 32'(8'h5A));

    // Both ports request every cycle from a fresh reset.
    reset_step();
    drive(1'b1, 1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 8'h02, 8'h00);
    for (int i = 0; i < 8; i++) begin
      step();
      if (i % 2 == 0) begin
        seq[0][i/2] = dut_g[0];
        seq[1][i/2] = dut_g[1];
      end
    end
    for (int i = 0; i < 4; i++) begin
      check("t2_rr_grant", i, 32'(seq[0][i]), 32'(i % 2));
      check("t3_fp_grant", i, 32'(seq[1][i]), 32'(0));
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00); step();

    // Port 1 writes 0xFF @0xFF, port 0 reads it, then reads untouched 0x00.
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 8'hFF); step();
    drive(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00); step();
    step();
    step();
    check("t4_rdata_ff", 0, 32'(rdata[0]), 32'(8'hFF));
    drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00); step();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00); step();
    check("t4_rdata_00", 0, 32'(rdata[0]), 32'(8'h00));

    // Reset lands in the ACCESS cycle of a write; the write must not reach memory.
    drive(1'b1, 1'b1, 8'h20, 8'h33, 1'b0, 1'b0, 8'h00, 8'h00); step();
    reset_step();
    drive(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00); step();
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00); step();
    check("t5_rdata", 0, 32'(rdata[0]), 32'(8'h00));
    check("t5_rsp0", 0, 32'(rsp0[0]), 32'(1));

    // Held read re-requested in the response cycle: two-cycle cadence.
    drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    for (int i = 0; i < 6; i++) begin
      step();
      check("t6_cadence", i, 32'(rsp0[0]), 32'(i % 2));
    end
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00); step();

    // Randomized traffic; a request stays stable until some instance accepts it.
    p0v = 1'b0; p0w = 1'b0; p0a = 8'h00; p0d = 8'h00;
    p1v = 1'b0; p1w = 1'b0; p1a = 8'h00; p1d = 8'h00;
    for (int n = 0; n < 400; n++) begin
      if (g_last[0] == 0 || g_last[1] == 0) p0v = 1'b0;
      else if (p0v) begin
        if ($urandom_range(0, 7) == 0) p0v = 1'b0;
      end else if ($urandom_range(0, 1) == 1) begin
        p0v = 1'b1; p0w = 1'($urandom_range(0, 1)); p0a = rand_addr(); p0d = 8'($urandom);
      end
      if (g_last[0] == 1 || g_last[1] == 1) p1v = 1'b0;
      else if (p1v) begin
        if ($urandom_range(0, 7) == 0) p1v = 1'b0;
      end else if ($urandom_range(0, 1) == 1) begin
        p1v = 1'b1; p1w = 1'($urandom_range(0, 1)); p1a = rand_addr(); p1d = 8'($urandom);
      end
      reset = ($urandom_range(0, 39) == 0);
      drive(p0v, p0w, p0a, p0d, p1v, p1w, p1a, p1d);
      step();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
